// File: rtl/serial_link_scheduler_pkg.sv
// Shared definitions for the serial link scheduler: FSM state encoding,
// link mode constants and the word-width derivation.
package serial_link_scheduler_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_START = 2'd1,
    SCH_RUN   = 2'd2,
    SCH_DRAIN = 2'd3
  } sch_state_e;

  localparam logic MODE_TX = 1'b0;
  localparam logic MODE_RX = 1'b1;

  function automatic int word_w(input int base);
    return 1 << base;
  endfunction

endpackage

// File: rtl/serial_link_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; last_grant advances only when a grant
// is actually accepted.
module rr_arb2
  import serial_link_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_tx,
  input  logic req_rx,
  input  logic accept,
  output logic gnt_tx,
  output logic gnt_rx
);

  logic last_grant;

  // Reset to RX so that TX wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= MODE_RX;
    end else if (accept) begin
      last_grant <= gnt_rx ? MODE_RX : MODE_TX;
    end
  end

  always_comb begin
    gnt_tx = 1'b0;
    gnt_rx = 1'b0;
    if (en) begin
      if (req_tx && req_rx) begin
        gnt_tx = (last_grant == MODE_RX);
        gnt_rx = (last_grant == MODE_TX);
      end else begin
        gnt_tx = req_tx;
        gnt_rx = req_rx;
      end
    end
  end

endmodule

// File: rtl/serial_link_scheduler.sv
// Command-side scheduler for the serial link core: arbitrates TX/RX word
// requests and runs one start/busy/finish handshake at a time.
module serial_link_scheduler
  import serial_link_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH_BASE = 5,
  parameter int START_TIMEOUT   = 8,
  localparam int W = word_w(DATA_WIDTH_BASE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_req_valid,
  output logic         tx_req_ready,
  input  logic [W-1:0] tx_req_data,
  output logic         tx_done,
  input  logic         rx_req_valid,
  output logic         rx_req_ready,
  output logic         rx_rsp_valid,
  output logic [W-1:0] rx_rsp_data,
  output logic         err,
  output logic         link_start,
  output logic         link_mode,
  output logic [W-1:0] link_transmit_data,
  input  logic         link_busy,
  input  logic         link_finish,
  input  logic [W-1:0] link_receive_data
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  sch_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic         start_nxt, mode_nxt, tx_done_nxt, rx_rsp_nxt, err_nxt;
  logic [W-1:0] txd_nxt, rxd_nxt;
  logic         accept, complete, abort;

  // A core that is still busy (e.g. not reset with us) blocks new grants.
  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     ((state == SCH_IDLE) && !link_busy),
    .req_tx (tx_req_valid),
    .req_rx (rx_req_valid),
    .accept (accept),
    .gnt_tx (tx_req_ready),
    .gnt_rx (rx_req_ready)
  );

  assign accept = tx_req_ready | rx_req_ready;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    start_nxt   = link_start;
    mode_nxt    = link_mode;
    txd_nxt     = link_transmit_data;
    rxd_nxt     = rx_rsp_data;
    tx_done_nxt = 1'b0;
    rx_rsp_nxt  = 1'b0;
    err_nxt     = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    case (state)
      SCH_IDLE: begin
        if (accept) begin
          state_nxt = SCH_START;
          cnt_nxt   = '0;
          start_nxt = 1'b1;
          mode_nxt  = rx_req_ready ? MODE_RX : MODE_TX;
          if (tx_req_ready) txd_nxt = tx_req_data;
        end
      end
      SCH_START: begin
        if (link_busy) begin
          state_nxt = SCH_RUN;
          start_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_nxt = SCH_IDLE;
            start_nxt = 1'b0;
            abort     = 1'b1;
          end
        end
      end
      SCH_RUN: begin
        // Finish wins over a simultaneous busy fall.
        if (link_finish) begin
          state_nxt = SCH_DRAIN;
          complete  = 1'b1;
          if (link_mode == MODE_RX) rxd_nxt = link_receive_data;
        end else if (!link_busy) begin
          state_nxt = SCH_IDLE;
          abort     = 1'b1;
        end
      end
      SCH_DRAIN: begin
        if (!link_busy) state_nxt = SCH_IDLE;
      end
      default: state_nxt = SCH_IDLE;
    endcase
    if (complete || abort) begin
      tx_done_nxt = (link_mode == MODE_TX);
      rx_rsp_nxt  = (link_mode == MODE_RX);
      err_nxt     = abort;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt                <= '0;
      link_start         <= 1'b0;
      link_mode          <= MODE_TX;
      link_transmit_data <= '0;
      rx_rsp_data        <= '0;
      tx_done            <= 1'b0;
      rx_rsp_valid       <= 1'b0;
      err                <= 1'b0;
    end else begin
      cnt                <= cnt_nxt;
      link_start         <= start_nxt;
      link_mode          <= mode_nxt;
      link_transmit_data <= txd_nxt;
      rx_rsp_data        <= rxd_nxt;
      tx_done            <= tx_done_nxt;
      rx_rsp_valid       <= rx_rsp_nxt;
      err                <= err_nxt;
    end
  end

endmodule
